elevator_scheduler: RTL
=======================

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter BUTTONS_WIDTH, default 8, number of floors (one request bit per floor) SHALL be supported.
REQ-002 Parameter LEVEL_WIDTH, default 3, SHALL give floor-index width, with 2**LEVEL_WIDTH >= BUTTONS_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high.
REQ-005 btn_in  input  BUTTONS_WIDTH  SHALL carry in-car floor buttons, level-sensitive.
REQ-006 btn_up_out / btn_down_out  input  BUTTONS_WIDTH each  SHALL carry hall up/down calls.
REQ-007 level  input  LEVEL_WIDTH  SHALL give current car floor from the car datapath.
REQ-008 arrive  input  1  SHALL be a one-cycle pulse from the car when stopped at level with doors opening.
REQ-009 door_closed  input  1  SHALL be a one-cycle pulse when doors are closed and the car may move.
REQ-010 target  output  LEVEL_WIDTH  SHALL give the next floor to drive to.
REQ-011 target_valid  output  1  SHALL be high when target is meaningful and the car may move.
REQ-012 dir  output  2  SHALL encode sweep direction: 00 idle, 01 up, 10 down.
REQ-013 pend_in / pend_up / pend_down  output  BUTTONS_WIDTH each  SHALL show latched requests (button lamps).

Function
REQ-014 Any input button bit high at a rising edge SHALL set the matching pending bit; bits stay set until served.
REQ-015 btn_up_out[BUTTONS_WIDTH-1] and btn_down_out[0] SHALL be ignored.
REQ-016 States SHALL be IDLE, UP, DOWN, DWELL; dir SHALL be 00 in IDLE, 01 in UP, 10 in DOWN, and keep the previous sweep value in DWELL.
REQ-017 IDLE: no pending bits -> stay; pending at level -> DWELL without motion; else any pending above level -> UP; else -> DOWN (above wins ties).
REQ-018 UP target SHALL be the lowest floor > level with pend_in or pend_up set; if none, the highest floor > level with pend_down set.
REQ-019 DOWN target SHALL be the highest floor < level with pend_in or pend_down set; if none, the lowest floor < level with pend_up set.
REQ-020 target/target_valid SHALL be registered and updated every cycle in UP/DOWN, so a new nearer call not yet passed retargets with 1-cycle latency.
REQ-021 arrive with level != target SHALL be ignored; arrive with level == target SHALL enter DWELL next cycle with target_valid low.
REQ-022 On entering DWELL, pend_in[level] SHALL clear plus the hall call matching dir; if no request remains beyond level in dir, the opposite hall call at level SHALL also clear.
REQ-023 In DWELL, button presses for the current level SHALL be absorbed (not latched); other floors latch normally.
REQ-024 On door_closed in DWELL: requests beyond level in dir -> same direction; else requests on the other side -> reverse; else IDLE.
REQ-025 When the same bit is set and cleared in one cycle, clear SHALL win.
REQ-026 UP with nothing pending above (calls cancelled by reset only) SHALL never occur; if level reaches BUTTONS_WIDTH-1 in UP or 0 in DOWN, next target SHALL come from the opposite side.

Reset
REQ-027 reset SHALL immediately force state IDLE, all pending vectors 0, target 0, target_valid 0, dir 00, including mid-sweep or mid-DWELL.
REQ-028 Button inputs SHALL not be latched while reset is high.

Structure
REQ-029 A shared package elevator_pkg SHALL hold the dir encoding, state encoding, BUTTONS_WIDTH and LEVEL_WIDTH defaults, reused by elevator and the bench.
REQ-030 One sub-module floor_search SHALL compute nearest set bit above/below a given level (lowest-above, highest-above, lowest-below, highest-below) combinationally.
REQ-031 Implementation SHALL be 120-400 lines RTL; no other sub-modules.

Verification
REQ-032 Reset, level=0, btn_in[7] pulse -> target=7, target_valid=1, dir=01 one cycle later; arrive at level 7 -> pend_in=0, DWELL.
REQ-033 At level 7 idle, btn_down_out[7] -> DWELL immediately, no motion, pend_down[7] cleared on entry.
REQ-034 UP from 0 to 7, btn_in[4] pressed while level=2 -> target becomes 4; arrive at 4 clears it; after door_closed target=7.
REQ-035 level 5 going down, btn_up_out[3] and btn_in[1] set -> target=1 first; after DWELL at 1 and door_closed, dir=01, target=3.
REQ-036 reset asserted mid-UP with pending 4, 6 -> all outputs zero asynchronously; after release, stays IDLE with no buttons.
REQ-037 In DWELL at level 3, btn_in[3] pulse -> pend_in[3] stays 0; btn_in[6] same cycle -> pend_in[6]=1.

Source files
------------

// File: rtl/elevator_scheduler_pkg.sv
// Shared encodings and default sizes for the elevator scheduler and its bench.
package elevator_pkg;

    localparam int DEF_BUTTONS_WIDTH = 8;
    localparam int DEF_LEVEL_WIDTH   = 3;

    typedef logic [1:0] dir_t;
    localparam dir_t DIR_IDLE = 2'b00;
    localparam dir_t DIR_UP   = 2'b01;
    localparam dir_t DIR_DOWN = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_UP    = 2'd1;
    localparam state_t ST_DOWN  = 2'd2;
    localparam state_t ST_DWELL = 2'd3;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Car/button side bundle: requests and car status in, target and lamps out.
interface elevator_scheduler_if
    import elevator_pkg::*;
#(
    parameter int BUTTONS_WIDTH = DEF_BUTTONS_WIDTH,
    parameter int LEVEL_WIDTH   = DEF_LEVEL_WIDTH
);
    logic [BUTTONS_WIDTH-1:0] btn_in;
    logic [BUTTONS_WIDTH-1:0] btn_up_out;
    logic [BUTTONS_WIDTH-1:0] btn_down_out;
    logic [LEVEL_WIDTH-1:0]   level;
    logic                     arrive;
    logic                     door_closed;
    logic [LEVEL_WIDTH-1:0]   target;
    logic                     target_valid;
    dir_t                     dir;
    logic [BUTTONS_WIDTH-1:0] pend_in;
    logic [BUTTONS_WIDTH-1:0] pend_up;
    logic [BUTTONS_WIDTH-1:0] pend_down;

    modport master (
        output btn_in, btn_up_out, btn_down_out, level, arrive, door_closed,
        input  target, target_valid, dir, pend_in, pend_up, pend_down
    );

    modport slave (
        input  btn_in, btn_up_out, btn_down_out, level, arrive, door_closed,
        output target, target_valid, dir, pend_in, pend_up, pend_down
    );

endinterface

// File: rtl/elevator_scheduler_floor_search.sv
// Nearest set bit strictly above / strictly below a floor index.
module floor_search
    import elevator_pkg::*;
#(
    parameter int BUTTONS_WIDTH = DEF_BUTTONS_WIDTH,
    parameter int LEVEL_WIDTH   = DEF_LEVEL_WIDTH
) (
    input  logic [BUTTONS_WIDTH-1:0] vec,
    input  logic [LEVEL_WIDTH-1:0]   level,
    output logic [LEVEL_WIDTH-1:0]   lo_above,
    output logic [LEVEL_WIDTH-1:0]   hi_above,
    output logic [LEVEL_WIDTH-1:0]   lo_below,
    output logic [LEVEL_WIDTH-1:0]   hi_below,
    output logic                     found_above,
    output logic                     found_below
);

    // Ascending scan: first hit is the lowest, last hit the highest.
    always_comb begin
        lo_above    = '0;
        hi_above    = '0;
        lo_below    = '0;
        hi_below    = '0;
        found_above = 1'b0;
        found_below = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (vec[i] && (LEVEL_WIDTH'(i) > level)) begin
                if (!found_above) lo_above = LEVEL_WIDTH'(i);
                hi_above    = LEVEL_WIDTH'(i);
                found_above = 1'b1;
            end
            if (vec[i] && (LEVEL_WIDTH'(i) < level)) begin
                if (!found_below) lo_below = LEVEL_WIDTH'(i);
                hi_below    = LEVEL_WIDTH'(i);
                found_below = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car sweep scheduler: latches calls, picks the next stop, clears served calls.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int BUTTONS_WIDTH = DEF_BUTTONS_WIDTH,
    parameter int LEVEL_WIDTH   = DEF_LEVEL_WIDTH
) (
    input logic                 clk,
    input logic                 reset,
    elevator_scheduler_if.slave bus
);

    localparam logic [BUTTONS_WIDTH-1:0] ONE       = {{(BUTTONS_WIDTH-1){1'b0}}, 1'b1};
    // No up call exists at the top floor, no down call at the bottom floor.
    localparam logic [BUTTONS_WIDTH-1:0] UP_MASK   = ~(ONE << (BUTTONS_WIDTH - 1));
    localparam logic [BUTTONS_WIDTH-1:0] DOWN_MASK = ~ONE;

    state_t                   state_q, state_d;
    dir_t                     dir_q, dir_d;
    logic [LEVEL_WIDTH-1:0]   target_q, target_d;
    logic                     valid_q, valid_d;
    logic [BUTTONS_WIDTH-1:0] pend_in_q, pend_in_d, pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
    logic [BUTTONS_WIDTH-1:0] set_in, set_up, set_dn, clr_in, clr_up, clr_dn, lvl_onehot;
    logic [LEVEL_WIDTH-1:0]   up_tgt, dn_tgt;
    logic                     up_ok, dn_ok, any_above, any_below, at_level, at_target;

    logic [LEVEL_WIDTH-1:0] un_lo_a, un_hi_a, un_lo_b, un_hi_b;
    logic [LEVEL_WIDTH-1:0] uf_lo_a, uf_hi_a, uf_lo_b, uf_hi_b;
    logic [LEVEL_WIDTH-1:0] dn_lo_a, dn_hi_a, dn_lo_b, dn_hi_b;
    logic [LEVEL_WIDTH-1:0] df_lo_a, df_hi_a, df_lo_b, df_hi_b;
    logic                   un_fa, un_fb, uf_fa, uf_fb, dn_fa, dn_fb, df_fa, df_fb;
    logic                   unused_search;

    // Up sweep: stops for car and up calls, then the farthest down call above.
    floor_search #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .LEVEL_WIDTH(LEVEL_WIDTH)) u_up_near (
        .vec(pend_in_q | pend_up_q), .level(bus.level),
        .lo_above(un_lo_a), .hi_above(un_hi_a), .lo_below(un_lo_b), .hi_below(un_hi_b),
        .found_above(un_fa), .found_below(un_fb)
    );
    floor_search #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .LEVEL_WIDTH(LEVEL_WIDTH)) u_up_far (
        .vec(pend_dn_q), .level(bus.level),
        .lo_above(uf_lo_a), .hi_above(uf_hi_a), .lo_below(uf_lo_b), .hi_below(uf_hi_b),
        .found_above(uf_fa), .found_below(uf_fb)
    );
    // Down sweep: stops for car and down calls, then the farthest up call below.
    floor_search #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .LEVEL_WIDTH(LEVEL_WIDTH)) u_dn_near (
        .vec(pend_in_q | pend_dn_q), .level(bus.level),
        .lo_above(dn_lo_a), .hi_above(dn_hi_a), .lo_below(dn_lo_b), .hi_below(dn_hi_b),
        .found_above(dn_fa), .found_below(dn_fb)
    );
    floor_search #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .LEVEL_WIDTH(LEVEL_WIDTH)) u_dn_far (
        .vec(pend_up_q), .level(bus.level),
        .lo_above(df_lo_a), .hi_above(df_hi_a), .lo_below(df_lo_b), .hi_below(df_hi_b),
        .found_above(df_fa), .found_below(df_fb)
    );

    assign unused_search = ^{un_hi_a, un_lo_b, un_hi_b, un_fb, uf_lo_a, uf_lo_b, uf_hi_b, uf_fb,
                             dn_lo_a, dn_hi_a, dn_lo_b, dn_fa, df_lo_a, df_hi_a, df_hi_b, df_fa};

    assign lvl_onehot = ONE << bus.level;
    assign any_above  = un_fa | uf_fa;
    assign any_below  = dn_fb | df_fb;
    assign at_level   = |((pend_in_q | pend_up_q | pend_dn_q) & lvl_onehot);
    assign at_target  = valid_q && (bus.level == target_q);

    // Candidate targets per sweep; an exhausted side falls back to the other side.
    always_comb begin
        up_ok = 1'b1;
        dn_ok = 1'b1;
        if (un_fa)      up_tgt = un_lo_a;
        else if (uf_fa) up_tgt = uf_hi_a;
        else if (dn_fb) up_tgt = dn_hi_b;
        else if (df_fb) up_tgt = df_lo_b;
        else begin
            up_tgt = target_q;
            up_ok  = 1'b0;
        end
        if (dn_fb)      dn_tgt = dn_hi_b;
        else if (df_fb) dn_tgt = df_lo_b;
        else if (un_fa) dn_tgt = un_lo_a;
        else if (uf_fa) dn_tgt = uf_hi_a;
        else begin
            dn_tgt = target_q;
            dn_ok  = 1'b0;
        end
    end

    // Sweep FSM, served-call clearing and registered target selection.
    always_comb begin
        state_d = state_q;
        clr_in  = '0;
        clr_up  = '0;
        clr_dn  = '0;
        set_in  = bus.btn_in;
        set_up  = bus.btn_up_out & UP_MASK;
        set_dn  = bus.btn_down_out & DOWN_MASK;
        if (state_q == ST_DWELL) begin
            set_in = set_in & ~lvl_onehot;
            set_up = set_up & ~lvl_onehot;
            set_dn = set_dn & ~lvl_onehot;
        end

        case (state_q)
            ST_IDLE: begin
                if (at_level)       state_d = ST_DWELL;
                else if (any_above) state_d = ST_UP;
                else if (any_below) state_d = ST_DOWN;
            end
            ST_UP, ST_DOWN: begin
                if (bus.arrive && at_target) state_d = ST_DWELL;
            end
            default: begin
                if (bus.door_closed) begin
                    if (dir_q == DIR_DOWN) begin
                        if (any_below)      state_d = ST_DOWN;
                        else if (any_above) state_d = ST_UP;
                        else                state_d = ST_IDLE;
                    end else begin
                        if (any_above)      state_d = ST_UP;
                        else if (any_below) state_d = ST_DOWN;
                        else                state_d = ST_IDLE;
                    end
                end
            end
        endcase

        // Opposite hall call at this floor is served too once the sweep turns here.
        if (state_d == ST_DWELL && state_q != ST_DWELL) begin
            clr_in = lvl_onehot;
            if (dir_q == DIR_UP) begin
                clr_up = lvl_onehot;
                if (!any_above) clr_dn = lvl_onehot;
            end else if (dir_q == DIR_DOWN) begin
                clr_dn = lvl_onehot;
                if (!any_below) clr_up = lvl_onehot;
            end else begin
                clr_up = lvl_onehot;
                clr_dn = lvl_onehot;
            end
        end

        pend_in_d = (pend_in_q | set_in) & ~clr_in;
        pend_up_d = (pend_up_q | set_up) & ~clr_up;
        pend_dn_d = (pend_dn_q | set_dn) & ~clr_dn;

        case (state_d)
            ST_IDLE:  dir_d = DIR_IDLE;
            ST_UP:    dir_d = DIR_UP;
            ST_DOWN:  dir_d = DIR_DOWN;
            default:  dir_d = dir_q;
        endcase

        target_d = target_q;
        valid_d  = 1'b0;
        // Once the car sits at its target, hold it so a late arrive is still honoured.
        if ((state_d == ST_UP || state_d == ST_DOWN) && state_q == state_d && at_target) begin
            valid_d = 1'b1;
        end else if (state_d == ST_UP) begin
            target_d = up_tgt;
            valid_d  = up_ok;
        end else if (state_d == ST_DOWN) begin
            target_d = dn_tgt;
            valid_d  = dn_ok;
        end
    end

    // State and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_IDLE;
            target_q  <= '0;
            valid_q   <= 1'b0;
            pend_in_q <= '0;
            pend_up_q <= '0;
            pend_dn_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            target_q  <= target_d;
            valid_q   <= valid_d;
            pend_in_q <= pend_in_d;
            pend_up_q <= pend_up_d;
            pend_dn_q <= pend_dn_d;
        end
    end

    assign bus.target       = target_q;
    assign bus.target_valid = valid_q;
    assign bus.dir          = dir_q;
    assign bus.pend_in      = pend_in_q;
    assign bus.pend_up      = pend_up_q;
    assign bus.pend_down    = pend_dn_q;

endmodule
